// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control FSM.
// MC_UTYPE_EN: when defined, LUI/AUIPC decode as legal U-type instructions.
package mc_ctrl_pkg;

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BRCMP = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;

    typedef struct packed {
        logic       legal;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic       is_mem;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
    } dec_t;

    // Static per-opcode control used by both DECODE and EXEC.
    function automatic dec_t decode_opcode(input logic [OPC_W-1:0] opc);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (opc)
            OPC_RTYPE: d.alu_op = ALU_FUNCT;
            OPC_IALU: begin
                d.alu_op  = ALU_FUNCT;
                d.imm_src = IMM_I;
            end
            OPC_LOAD: begin
                d.alu_op  = ALU_ADD;
                d.imm_src = IMM_I;
                d.is_mem  = 1'b1;
            end
            OPC_STORE: begin
                d.alu_op   = ALU_ADD;
                d.imm_src  = IMM_S;
                d.is_mem   = 1'b1;
                d.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                d.alu_op    = ALU_BRCMP;
                d.imm_src   = IMM_B;
                d.is_branch = 1'b1;
            end
            OPC_JAL: begin
                d.imm_src = IMM_J;
                d.is_jal  = 1'b1;
            end
`ifdef MC_UTYPE_EN
            OPC_LUI, OPC_AUIPC: begin
                d.alu_op  = ALU_ADD;
                d.imm_src = IMM_U;
            end
`endif
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter: counts un-acked request cycles, flags the last allowed one.
module mc_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with req/ack memories and sticky trap.
// MC_UTYPE_EN (see mc_ctrl_pkg) enables LUI/AUIPC; otherwise they trap as illegal.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ILEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ILEN-1:0] instr,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    input  logic            branch_taken,
    output logic            imem_req,
    output logic            ir_we,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            reg_write,
    output logic [1:0]      alu_op,
    output logic [2:0]      imm_src,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            illegal_op,
    output logic            timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             wait_en;
    logic             expired;
    dec_t             dec;
    logic             instr_unused_c;

    // Only the opcode field is consumed here; the rest goes to the datapath.
    assign instr_unused_c = ^instr[ILEN-1:OPC_W];
    assign dec = decode_opcode(opcode_q);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!wait_en),
        .enable_i  (wait_en),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        wait_en     = 1'b0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_write   = 1'b0;
        alu_op      = ALU_ADD;
        imm_src     = IMM_I;
        pc_write    = 1'b0;
        pc_src      = PC_PLUS4;
        illegal_op  = illegal_q;
        timeout_err = timeout_q;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                wait_en  = !imem_ack;
                if (imem_ack) begin
                    ir_we    = 1'b1;
                    opcode_d = instr[OPC_W-1:0];
                    state_d  = DECODE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            DECODE: begin
                alu_op  = dec.alu_op;
                imm_src = dec.imm_src;
                if (dec.legal) begin
                    state_d = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            EXEC: begin
                alu_op  = dec.alu_op;
                imm_src = dec.imm_src;
                if (dec.is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
                    state_d  = FETCH;
                end else if (dec.is_mem) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec.is_store;
                wait_en  = !dmem_ack;
                if (dmem_ack) begin
                    if (dec.is_store) begin
                        pc_write = 1'b1;
                        pc_src   = PC_PLUS4;
                        state_d  = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = dec.is_jal ? PC_JUMP : PC_PLUS4;
                state_d   = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset silences every output, including in-flight requests.
        if (rst) begin
            imem_req    = 1'b0;
            ir_we       = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            reg_write   = 1'b0;
            alu_op      = ALU_ADD;
            imm_src     = IMM_I;
            pc_write    = 1'b0;
            pc_src      = PC_PLUS4;
            illegal_op  = 1'b0;
            timeout_err = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Sequential successor to the single-cycle main decoder.
- Drives a multi-cycle RV32 datapath through FETCH/DECODE/EXEC/MEM/WB states.
- Uses req/ack handshakes to instruction and data memory, which may have variable latency.
- Adds per-state control sequencing, a memory-wait timeout, and a sticky trap on illegal opcodes or timeouts.
- Sits between the memory interfaces and the shared datapath (regfile, ALU, PC mux).

Parameters:
- ILEN, 32: instruction width; opcode is instr[6:0].
- TIMEOUT, 16: maximum wait cycles for an ack before trapping (>=1).
- CNT_W, $clog2(TIMEOUT+1): wait counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr  in  ILEN  instruction word from imem, valid when imem_ack=1
- imem_ack  in  1  imem completes the fetch
- dmem_ack  in  1  dmem completes the access
- branch_taken  in  1  ALU compare result, sampled in EXEC for branches
- imem_req  out  1  fetch request
- ir_we  out  1  instruction-register write strobe
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load; valid while dmem_req=1
- reg_write  out  1  regfile write enable
- alu_op  out  2  00 add, 01 branch-compare, 10 funct-decoded
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- pc_write  out  1  PC update strobe
- pc_src  out  2  00 pc+4, 01 branch target, 10 jump target
- illegal_op  out  1  sticky: unsupported opcode
- timeout_err  out  1  sticky: memory ack timeout

Behaviour:
- While rst=1, every output is 0; on the next edge state=FETCH, wait counter=0, opcode register=0, sticky flags cleared.
- Outputs are decoded from the state register and latched opcode. Exceptions: ir_we=FETCH&imem_ack, and pc_src in EXEC depends on branch_taken.
- FETCH:
  - imem_req=1 every cycle in this state.
  - On imem_ack (including the first cycle): ir_we=1, opcode<=instr[6:0], go to DECODE.
- DECODE (one cycle):
  - imm_src/alu_op set per opcode, as in EXEC.
  - Unsupported opcode -> TRAP, otherwise -> EXEC.
- EXEC (one cycle), by opcode:
  - R-type 0110011: alu_op=10 -> WB.
  - I-ALU 0010011: alu_op=10, imm_src=000 -> WB.
  - Load 0000011 / store 0100011: alu_op=00, imm_src 000/001 -> MEM.
  - Branch 1100011: alu_op=01, imm_src=010, pc_write=1, pc_src=branch_taken?01:00 -> FETCH.
  - JAL 1101111: imm_src=011 -> WB.
- MEM:
  - dmem_req=1 held; dmem_we=1 for store.
  - On dmem_ack: load -> WB; store -> pc_write=1, pc_src=00 -> FETCH.
- WB (one cycle): reg_write=1, pc_write=1, pc_src=10 for JAL else 00 -> FETCH.
- TRAP:
  - All strobes 0; illegal_op or timeout_err held at 1.
  - Leaves only on rst.
- Handshake:
  - req stays high until ack; ack while the matching req=0 is ignored.
  - Exactly one transfer per ack.
  - A request is never withdrawn except by rst.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle without ack.
  - If counter==TIMEOUT-1 and no ack -> TRAP with timeout_err=1. An ack on that same cycle wins.
- Fixed latencies: DECODE, EXEC and WB are 1 cycle each. Minimum cycle counts:
  - ALU op / JAL: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- rst mid-MEM or mid-FETCH: req drops during reset and no strobe is issued.

Optional Feature:
- Macro MC_UTYPE_EN.
- Defined: LUI 0110111 and AUIPC 0010111 are accepted; imm_src=100, alu_op=00, EXEC -> WB.
- Undefined: both opcodes -> TRAP with illegal_op.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode localparams;
  - state enum {FETCH, DECODE, EXEC, MEM, WB, TRAP};
  - alu_op, imm_src and pc_src encodings.
- One natural sub-module: mc_wait_timer, the TIMEOUT counter with clear/enable/expired.

Test Plan:
- R-type 0x00B50533, imem_ack delayed 2 cycles -> FETCH 3 cycles, ir_we=1 on cycle 3, DECODE, EXEC alu_op=10, WB reg_write=1 and pc_write=1 with pc_src=00; total 6 cycles.
- Load 0x0002A303 with dmem_ack on the first MEM cycle -> dmem_req=1, dmem_we=0 for one cycle, then WB reg_write=1; 5 cycles total.
- Branch 0x00B50463:
  - branch_taken=1 -> EXEC pc_write=1, pc_src=01;
  - branch_taken=0 -> pc_src=00;
  - reg_write never asserted.
- Store 0x00B2A023 with dmem_ack after 3 cycles -> dmem_we=1 for 4 cycles, pc_write on the ack cycle, no reg_write.
- Opcode 7'b1111111 -> TRAP after DECODE, illegal_op=1 stays set for 20 cycles, cleared by rst.
- TIMEOUT=4 with no imem_ack -> TRAP after 4 FETCH cycles, timeout_err=1. Also: rst asserted during MEM -> dmem_req=0 while rst=1, then FETCH.
- MC_UTYPE_EN defined vs undefined, LUI 0x123452B7 -> imm_src=100 then WB, vs illegal_op=1.
